// File: rtl/hpm_sampler.sv
// HPM counter sampler: sweeps enabled mhpmcounterN over the shared CSR port,
// optionally clears them, services overflow bits and streams samples out.
//
// state   | meaning
// IDLE    | waiting for start_i, timer expiry or a pending trigger
// SEL     | pick lowest remaining enabled counter index
// RD_CNT  | read mhpmcounterN, capture into sample data
// CLR_CNT | write 0 to mhpmcounterN (clear mode only)
// PUSH    | present (N, value) on the sample port until accepted
// RD_EVT  | read mhpmeventN for overflow service
// WR_EVT  | write mhpmeventN back with bit 63 cleared
// DONE    | one-cycle end-of-sweep pulse
module hpm_sampler #(
   parameter int CSR_ADDR_WIDTH   = 12,
   parameter int XLEN             = 64,
   parameter int HPM_NUM_COUNTERS = 29,
   parameter int PERIOD_WIDTH     = 32
) (
   input  logic                      clk_i,
   input  logic                      rstn_i,
   input  logic                      start_i,
   input  logic [PERIOD_WIDTH-1:0]   period_i,
   input  logic [31:0]               mask_i,
   input  logic                      clear_i,
   input  logic                      csr_gnt_i,
   output logic                      csr_req_o,
   output logic [CSR_ADDR_WIDTH-1:0] csr_addr_o,
   output logic                      csr_we_o,
   output logic [XLEN-1:0]           csr_wdata_o,
   input  logic [XLEN-1:0]           csr_rdata_i,
   input  logic [31:3]               ovf_bits_i,
   output logic                      smp_valid_o,
   input  logic                      smp_ready_i,
   output logic [4:0]                smp_idx_o,
   output logic [XLEN-1:0]           smp_data_o,
   output logic                      busy_o,
   output logic                      done_o,
   output logic                      missed_o
);

   if (XLEN != 64) begin : g_xlen_check
      $error("hpm_sampler: only XLEN=64 is supported");
   end

   localparam logic [CSR_ADDR_WIDTH-1:0] CSR_MHPM_COUNTER_3 = CSR_ADDR_WIDTH'(12'hB03);
   localparam logic [CSR_ADDR_WIDTH-1:0] CSR_MHPM_EVENT_3   = CSR_ADDR_WIDTH'(12'h323);
   localparam int MAX_IDX = HPM_NUM_COUNTERS + 2;

   function automatic logic [31:0] range_mask();
      logic [31:0] m;
      m = '0;
      for (int i = 0; i < 32; i++) m[i] = (i >= 3) && (i <= MAX_IDX);
      return m;
   endfunction

   localparam logic [31:0] RANGE_MASK = range_mask();

   typedef enum logic [2:0] {
      S_IDLE, S_SEL, S_RD_CNT, S_CLR_CNT, S_PUSH, S_RD_EVT, S_WR_EVT, S_DONE
   } state_t;

   state_t                  state_q;
   logic [PERIOD_WIDTH-1:0] timer_q;
   logic                    pending_q;
   logic                    missed_q;
   logic [31:0]             mask_q;
   logic                    clear_q;
   logic [4:0]              idx_q;
   logic [XLEN-1:0]         data_q;
   logic [XLEN-1:0]         evt_q;

   logic                      timer_expire;
   logic                      trigger;
   logic [31:0]               cand;
   logic                      sel_found;
   logic [4:0]                sel_idx;
   logic [31:0]               ovf_full;
   logic [4:0]                offset;
   logic [CSR_ADDR_WIDTH-1:0] addr_off;

   assign timer_expire = (period_i != '0) && (timer_q == period_i - 1'b1);
   assign trigger      = start_i | timer_expire;
   assign cand         = mask_q & RANGE_MASK;
   assign ovf_full     = {ovf_bits_i, 3'b000};
   assign offset       = idx_q - 5'd3;
   assign addr_off     = CSR_ADDR_WIDTH'(offset);

   // Descending scan so the last hit is the lowest enabled index.
   always_comb begin
      sel_found = 1'b0;
      sel_idx   = '0;
      for (int i = 31; i >= 0; i--) begin
         if (cand[i]) begin
            sel_found = 1'b1;
            sel_idx   = 5'(i);
         end
      end
   end

   always_ff @(posedge clk_i or negedge rstn_i) begin
      if (!rstn_i) begin
         state_q   <= S_IDLE;
         timer_q   <= '0;
         pending_q <= 1'b0;
         missed_q  <= 1'b0;
         mask_q    <= '0;
         clear_q   <= 1'b0;
         idx_q     <= '0;
         data_q    <= '0;
         evt_q     <= '0;
      end else begin
         if (period_i == '0 || timer_expire) timer_q <= '0;
         else                                timer_q <= timer_q + 1'b1;

         missed_q <= 1'b0;
         if (state_q != S_IDLE && trigger) begin
            if (pending_q) missed_q  <= 1'b1;
            else           pending_q <= 1'b1;
         end

         case (state_q)
            S_IDLE: begin
               if (trigger || pending_q) begin
                  mask_q    <= mask_i;
                  clear_q   <= clear_i;
                  pending_q <= 1'b0;
                  state_q   <= S_SEL;
               end
            end
            S_SEL: begin
               if (sel_found) begin
                  idx_q   <= sel_idx;
                  state_q <= S_RD_CNT;
               end else begin
                  state_q <= S_DONE;
               end
            end
            S_RD_CNT: begin
               if (csr_gnt_i) begin
                  data_q  <= csr_rdata_i;
                  state_q <= clear_q ? S_CLR_CNT : S_PUSH;
               end
            end
            S_CLR_CNT: if (csr_gnt_i) state_q <= S_PUSH;
            S_PUSH: begin
               if (smp_ready_i) begin
                  if (ovf_full[idx_q]) begin
                     state_q <= S_RD_EVT;
                  end else begin
                     mask_q[idx_q] <= 1'b0;
                     state_q       <= S_SEL;
                  end
               end
            end
            S_RD_EVT: begin
               if (csr_gnt_i) begin
                  evt_q   <= csr_rdata_i;
                  state_q <= S_WR_EVT;
               end
            end
            S_WR_EVT: begin
               if (csr_gnt_i) begin
                  mask_q[idx_q] <= 1'b0;
                  state_q       <= S_SEL;
               end
            end
            S_DONE:  state_q <= S_IDLE;
            default: state_q <= S_IDLE;
         endcase
      end
   end

   assign csr_req_o   = (state_q == S_RD_CNT) || (state_q == S_CLR_CNT) ||
                        (state_q == S_RD_EVT) || (state_q == S_WR_EVT);
   assign csr_we_o    = (state_q == S_CLR_CNT) || (state_q == S_WR_EVT);
   assign csr_addr_o  = ((state_q == S_RD_EVT) || (state_q == S_WR_EVT)) ? CSR_MHPM_EVENT_3 + addr_off :
                        ((state_q == S_RD_CNT) || (state_q == S_CLR_CNT)) ? CSR_MHPM_COUNTER_3 + addr_off :
                        '0;
   assign csr_wdata_o = (state_q == S_WR_EVT) ? {1'b0, evt_q[XLEN-2:0]} : '0;
   assign smp_valid_o = (state_q == S_PUSH);
   assign smp_idx_o   = idx_q;
   assign smp_data_o  = data_q;
   assign busy_o      = (state_q != S_IDLE);
   assign done_o      = (state_q == S_DONE);
   assign missed_o    = missed_q;

endmodule

// File: tb/tb_hpm_sampler.sv
// Directed bench for hpm_sampler: CSR file model, sweep vector table and
// hand sequences for backpressure, pending/missed triggers and mid-sweep reset.
module tb_hpm_sampler;

   logic        clk_i = 1'b0;
   logic        rstn_i = 1'b0;
   logic        start_i = 1'b0;
   logic [31:0] period_i = '0;
   logic [31:0] mask_i = '0;
   logic        clear_i = 1'b0;
   logic        csr_gnt_i;
   logic        csr_req_o;
   logic [11:0] csr_addr_o;
   logic        csr_we_o;
   logic [63:0] csr_wdata_o;
   logic [63:0] csr_rdata_i;
   logic [31:3] ovf_bits_i = '0;
   logic        smp_valid_o;
   logic        smp_ready_i = 1'b1;
   logic [4:0]  smp_idx_o;
   logic [63:0] smp_data_o;
   logic        busy_o;
   logic        done_o;
   logic        missed_o;
   logic        gnt_en = 1'b1;

   always #5 clk_i = ~clk_i;
   assign csr_gnt_i = gnt_en;

   hpm_sampler dut (
      .clk_i(clk_i), .rstn_i(rstn_i), .start_i(start_i), .period_i(period_i),
      .mask_i(mask_i), .clear_i(clear_i), .csr_gnt_i(csr_gnt_i), .csr_req_o(csr_req_o),
      .csr_addr_o(csr_addr_o), .csr_we_o(csr_we_o), .csr_wdata_o(csr_wdata_o),
      .csr_rdata_i(csr_rdata_i), .ovf_bits_i(ovf_bits_i), .smp_valid_o(smp_valid_o),
      .smp_ready_i(smp_ready_i), .smp_idx_o(smp_idx_o), .smp_data_o(smp_data_o),
      .busy_o(busy_o), .done_o(done_o), .missed_o(missed_o)
   );

   logic [63:0] ctr [32];
   logic [63:0] evt [32];

   always_comb begin
      csr_rdata_i = '0;
      if (csr_addr_o >= 12'hB03 && csr_addr_o <= 12'hB1F)
         csr_rdata_i = ctr[5'(csr_addr_o - 12'hB00)];
      else if (csr_addr_o >= 12'h323 && csr_addr_o <= 12'h33F)
         csr_rdata_i = evt[5'(csr_addr_o - 12'h320)];
   end

   int          n_smp, n_rd, n_wr, n_missed, n_done, we_viol;
   logic [4:0]  first_idx, last_idx;
   logic [63:0] first_data;
   logic [11:0] last_raddr, last_waddr;
   logic [63:0] last_wdata;

   always @(negedge clk_i) begin
      if (rstn_i) begin
         if (csr_we_o && !csr_req_o) we_viol++;
         if (csr_req_o && csr_gnt_i) begin
            if (csr_we_o) begin
               n_wr++;
               last_waddr = csr_addr_o;
               last_wdata = csr_wdata_o;
               if (csr_addr_o >= 12'hB03 && csr_addr_o <= 12'hB1F)
                  ctr[5'(csr_addr_o - 12'hB00)] = csr_wdata_o;
               else if (csr_addr_o >= 12'h323 && csr_addr_o <= 12'h33F)
                  evt[5'(csr_addr_o - 12'h320)] = csr_wdata_o;
            end else begin
               n_rd++;
               last_raddr = csr_addr_o;
            end
         end
         if (smp_valid_o && smp_ready_i) begin
            if (n_smp == 0) begin
               first_idx  = smp_idx_o;
               first_data = smp_data_o;
            end
            last_idx = smp_idx_o;
            n_smp++;
         end
         if (missed_o) n_missed++;
         if (done_o)   n_done++;
      end
   end

   int tests = 0;
   int failed = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      tests++;
      if (act !== exp) begin
         failed++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic clear_log();
      n_smp = 0; n_rd = 0; n_wr = 0; n_missed = 0; n_done = 0;
      first_idx = '0; last_idx = '0; first_data = '0;
      last_raddr = '0; last_waddr = '0; last_wdata = '0;
   endtask

   task automatic init_mem();
      for (int n = 0; n < 32; n++) begin
         ctr[n] = 64'(n) * 64'd1000 + 64'd1;
         evt[n] = {1'b1, 63'(n + 2)};
      end
      ctr[3] = 64'd100;
      ctr[4] = 64'd7;
      ctr[5] = 64'd9;
   endtask

   task automatic tick();
      @(posedge clk_i);
      #1;
   endtask

   task automatic pulse_start();
      tick();
      start_i = 1'b1;
      tick();
      start_i = 1'b0;
   endtask

   task automatic wait_done(input string name);
      int k;
      k = 0;
      while (!done_o && k < 3000) begin
         tick();
         k++;
      end
      if (!done_o) begin
         tests++;
         failed++;
         $display("FAIL %s: done_o not seen within %0d cycles", name, k);
      end
      tick();
   endtask

   typedef struct {
      logic [31:0] mask;
      logic        clr;
      logic [28:0] ovf;
      int          n_smp;
      int          n_rd;
      int          n_wr;
      logic [4:0]  first_idx;
      logic [63:0] first_data;
      logic [4:0]  last_idx;
      logic [11:0] last_raddr;
      logic [11:0] last_waddr;
      logic [63:0] last_wdata;
   } vec_t;

   vec_t vecs [8];
   logic hold_ok;
   logic [4:0]  bp_idx;
   logic [63:0] bp_data;
   int k;

   initial begin
      vecs[0] = '{32'h0000_0008, 1'b0, 29'h0, 1, 1, 0, 5'd3, 64'd100, 5'd3, 12'hB03, 12'h000, 64'd0};
      vecs[1] = '{32'h0000_0030, 1'b1, 29'h0, 2, 2, 2, 5'd4, 64'd7, 5'd5, 12'hB05, 12'hB05, 64'd0};
      vecs[2] = '{32'h0000_0000, 1'b0, 29'h0, 0, 0, 0, 5'd0, 64'd0, 5'd0, 12'h000, 12'h000, 64'd0};
      vecs[3] = '{32'h0000_0007, 1'b1, 29'h0, 0, 0, 0, 5'd0, 64'd0, 5'd0, 12'h000, 12'h000, 64'd0};
      vecs[4] = '{32'h0000_0008, 1'b0, 29'h1, 1, 2, 1, 5'd3, 64'd100, 5'd3, 12'h323, 12'h323, 64'd5};
      vecs[5] = '{32'h8000_0000, 1'b0, 29'h0, 1, 1, 0, 5'd31, 64'd31001, 5'd31, 12'hB1F, 12'h000, 64'd0};
      vecs[6] = '{32'hFFFF_FFFF, 1'b0, 29'h0, 29, 29, 0, 5'd3, 64'd100, 5'd31, 12'hB1F, 12'h000, 64'd0};
      vecs[7] = '{32'h8000_0008, 1'b1, 29'h1000_0000, 2, 3, 3, 5'd3, 64'd100, 5'd31, 12'h33F, 12'h33F, 64'd33};

      we_viol = 0;
      clear_log();
      init_mem();
      #1;
      check("reset_outputs", {busy_o, done_o, missed_o, smp_valid_o, csr_req_o, csr_we_o,
                              csr_addr_o, smp_idx_o, smp_data_o, csr_wdata_o}, '0);
      tick();
      tick();
      rstn_i = 1'b1;
      tick();
      check("idle_after_reset", {busy_o, csr_req_o}, '0);

      // empty mask: DONE two cycles after the trigger, no CSR traffic
      clear_log();
      mask_i = 32'h0;
      tick();
      start_i = 1'b1;
      tick();
      start_i = 1'b0;
      check("empty_sel_busy", {busy_o, done_o}, 2'b10);
      tick();
      check("empty_done_pulse", {busy_o, done_o}, 2'b11);
      tick();
      check("empty_back_idle", {busy_o, done_o}, 2'b00);
      check("empty_no_reads", 64'(n_rd), 64'd0);

      for (int i = 0; i < 8; i++) begin
         clear_log();
         init_mem();
         mask_i     = vecs[i].mask;
         clear_i    = vecs[i].clr;
         ovf_bits_i = vecs[i].ovf;
         pulse_start();
         wait_done($sformatf("vec%0d_done", i));
         check($sformatf("vec%0d_n_smp", i), 64'(n_smp), 64'(vecs[i].n_smp));
         check($sformatf("vec%0d_n_rd", i), 64'(n_rd), 64'(vecs[i].n_rd));
         check($sformatf("vec%0d_n_wr", i), 64'(n_wr), 64'(vecs[i].n_wr));
         if (vecs[i].n_smp > 0) begin
            check($sformatf("vec%0d_first_idx", i), 64'(first_idx), 64'(vecs[i].first_idx));
            check($sformatf("vec%0d_first_data", i), first_data, vecs[i].first_data);
            check($sformatf("vec%0d_last_idx", i), 64'(last_idx), 64'(vecs[i].last_idx));
         end
         if (vecs[i].n_rd > 0)
            check($sformatf("vec%0d_last_raddr", i), 64'(last_raddr), 64'(vecs[i].last_raddr));
         if (vecs[i].n_wr > 0) begin
            check($sformatf("vec%0d_last_waddr", i), 64'(last_waddr), 64'(vecs[i].last_waddr));
            check($sformatf("vec%0d_last_wdata", i), last_wdata, vecs[i].last_wdata);
         end
         if (vecs[i].clr && vecs[i].n_smp > 0)
            check($sformatf("vec%0d_ctr_cleared", i), ctr[vecs[i].last_idx], 64'd0);
         ovf_bits_i = '0;
      end

      // sample port backpressure
      clear_log();
      init_mem();
      mask_i = 32'h30;
      clear_i = 1'b0;
      smp_ready_i = 1'b0;
      pulse_start();
      k = 0;
      while (!smp_valid_o && k < 50) begin
         tick();
         k++;
      end
      check("bp_valid_seen", 64'(smp_valid_o), 64'd1);
      bp_idx  = smp_idx_o;
      bp_data = smp_data_o;
      check("bp_idx", 64'(bp_idx), 64'd4);
      check("bp_data", bp_data, 64'd7);
      hold_ok = 1'b1;
      repeat (10) begin
         tick();
         if (!smp_valid_o || smp_idx_o != bp_idx || smp_data_o != bp_data || csr_req_o)
            hold_ok = 1'b0;
      end
      check("bp_hold_stable", 64'(hold_ok), 64'd1);
      check("bp_no_new_reads", 64'(n_rd), 64'd1);
      smp_ready_i = 1'b1;
      wait_done("bp_done");
      check("bp_n_smp", 64'(n_smp), 64'd2);
      check("bp_last_idx", 64'(last_idx), 64'd5);

      // periodic trigger while grant is withheld: pending, then missed
      clear_log();
      init_mem();
      mask_i = 32'h8;
      clear_i = 1'b0;
      gnt_en = 1'b0;
      period_i = 32'd50;
      k = 0;
      while (n_missed == 0 && k < 300) begin
         tick();
         k++;
      end
      check("per_missed_seen", 64'(n_missed), 64'd1);
      check("per_busy_stuck", 64'(busy_o), 64'd1);
      check("per_no_smp_yet", 64'(n_smp), 64'd0);
      period_i = '0;
      gnt_en = 1'b1;
      wait_done("per_first_done");
      wait_done("per_pending_done");
      check("per_n_done", 64'(n_done), 64'd2);
      check("per_n_smp", 64'(n_smp), 64'd2);
      check("per_missed_once", 64'(n_missed), 64'd1);
      tick();
      check("per_idle_after", 64'(busy_o), 64'd0);

      // reset asserted mid-read
      clear_log();
      init_mem();
      mask_i = 32'h8;
      clear_i = 1'b1;
      gnt_en = 1'b0;
      pulse_start();
      k = 0;
      while (!csr_req_o && k < 20) begin
         tick();
         k++;
      end
      check("rst_in_rd_cnt", {52'd0, csr_addr_o}, 64'hB03);
      #2;
      rstn_i = 1'b0;
      #1;
      check("rst_outputs_zero", {busy_o, done_o, missed_o, smp_valid_o, csr_req_o, csr_we_o,
                                 csr_addr_o, smp_idx_o, smp_data_o, csr_wdata_o}, '0);
      tick();
      tick();
      gnt_en = 1'b1;
      rstn_i = 1'b1;
      repeat (5) tick();
      check("rst_no_write", 64'(n_wr), 64'd0);
      check("rst_idle", {busy_o, csr_req_o}, '0);
      check("rst_ctr_intact", ctr[3], 64'd100);

      check("we_only_with_req", 64'(we_viol), 64'd0);

      $display("[TB] %0d tests run, %0d failed", tests, failed);
      $finish;
   end

endmodule
